bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
- Time-multiplexes a multi-digit packed-BCD value onto one shared seven-segment decoder and a set of common-anode digit enables.
- Sits directly upstream of the BCD-to-seven-segment decoder: digit_bcd[3:0] drives decoder inputs b3..b0, and anode selects which physical digit is lit.
- Adds frame-synchronous (tear-free) value loading, leading-zero blanking and invalid-digit suppression.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
PRESCALE, 100000, clk cycles per digit slot (>=1; 1 kHz slot rate at 100 MHz)
ANODE_ACTIVE_LOW, 1, 1: anode bit 0 = digit lit; 0: anode bit 1 = digit lit

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = scanning runs; 0 = display dark, scan held
load  input  1  single-cycle strobe capturing value
value  input  4*NUM_DIGITS  packed BCD, digit i in bits [4i+3:4i], digit 0 = least significant
lz_blank  input  1  1 = enable leading-zero blanking
digit_bcd  output  4  BCD code of current slot, to decoder b3..b0 (bit 3 = b3)
anode  output  NUM_DIGITS  per-digit enable, polarity per ANODE_ACTIVE_LOW
digit_idx  output  clog2(NUM_DIGITS)  index of current slot
frame_tick  output  1  one-cycle pulse when digit_idx wraps to 0
bad_digit  output  1  1 while display register holds any nibble > 9

Behaviour:
- Reset (async, active-high) clears everything: pending and display registers = 0, pending_valid = 0, prescaler = 0, digit_idx = 0, digit_bcd = 0, anode = all inactive, frame_tick = 0, bad_digit = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable = 1.
  - The terminal count is the "slot tick". On the slot tick edge the prescaler returns to 0.
  - With PRESCALE = 1, a slot tick occurs every cycle.
- Slot advance:
  - On each slot tick, digit_idx increments. digit_idx = NUM_DIGITS-1 wraps to 0.
  - On the wrap edge, frame_tick = 1 for exactly one cycle.
  - digit_bcd and anode change on the same edge as digit_idx and always describe the new index.
- Load:
  - load = 1 captures value into the pending register and sets pending_valid. If several loads arrive before a frame boundary, the last one wins.
  - At a frame boundary (the wrap to 0), a pending value moves into the display register and pending_valid clears. Digit 0 of the new frame already shows the new value.
  - A load in the same cycle as the wrap edge is not applied at that boundary; it is applied at the next one.
  - When enable = 0, a load goes directly to the display register on the next edge.
- Per-slot output for the current slot i, with d = display nibble i:
  - Invalid digit (d > 9): anode all inactive, digit_bcd = 0.
  - Blanked (lz_blank = 1, i > 0, and d and every higher-index nibble are 0): anode all inactive, digit_bcd = 0.
  - Otherwise: anode has only bit i active, digit_bcd = d.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- bad_digit: recomputed whenever the display register is written; held otherwise.
- enable = 0:
  - Prescaler and digit_idx forced to 0.
  - anode all inactive, digit_bcd = 0, frame_tick = 0.
  - On the first cycle with enable = 1, slot 0 is driven on the next edge and the prescaler starts from 0.
- Reset mid-scan: immediate return to the reset state. Anodes go inactive asynchronously.
- At most one anode bit is ever active.

Test Plan:
- Basic scan: NUM_DIGITS=4, PRESCALE=4, rst pulse, enable=1, load value=16'h1234, lz_blank=0. After the first frame boundary:
  - digit_bcd sequence 4,3,2,1, each held 4 cycles.
  - anode (active low) 1110,1101,1011,0111.
  - frame_tick pulses every 16 cycles, coincident with idx 0.
- Tear-free load: while displaying 16'h1234, load 16'h5678 when digit_idx = 1. Remaining slots still show 2,1; the next frame shows 8,7,6,5. Two loads (16'hAAAA is not required; use 16'h1111 then 16'h2222) before the boundary: only 2222 is shown.
- Leading-zero blanking, lz_blank=1:
  - value 16'h0042: slots 2 and 3 have all anodes inactive; slots 0 and 1 show 2, 4.
  - value 16'h0000: only slot 0 lit, showing 0.
  - value 16'h0402: slot 1 shows 0, lit.
- Invalid digit: value 16'h1A23 gives bad_digit = 1 after apply; slot 2 is dark with digit_bcd = 0; other slots show 3,2,1. A reload with 16'h1023 clears bad_digit at the next frame boundary.
- Enable control: deassert enable mid-slot. Next edge: anodes inactive, digit_idx = 0. A load while disabled applies immediately. Reassert enable: slot 0 is lit for a full 4 cycles.
- Async reset: assert rst between clock edges during scanning. anode goes inactive without a clock edge; all outputs match reset values; after release and load 16'h0001, digit 0 shows 1.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
//   Time-multiplexes a packed-BCD value onto one shared seven-segment decoder
//   and a bank of digit enables. It loads new values only at frame boundaries,
//   so a frame never shows a mix of old and new digits. It can blank leading
//   zeros and it keeps any slot dark whose nibble is not a valid BCD code.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous, active-high reset
//   enable     : 1 = scanning runs, 0 = display dark and scan held at slot 0
//   load       : single-cycle strobe that captures value
//   value      : packed BCD, digit i in bits [4i+3:4i], digit 0 = least significant
//   lz_blank   : 1 = blank leading zeros (digit 0 is never blanked)
//   digit_bcd  : BCD code of the current slot, drives decoder b3..b0
//   anode      : per-digit enable, polarity set by ANODE_ACTIVE_LOW
//   digit_idx  : index of the current slot
//   frame_tick : one-cycle pulse on the edge where digit_idx wraps to 0
//   bad_digit  : 1 while the display register holds any nibble > 9
module bcd_display_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int PRESCALE         = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          lz_blank,
  output logic [3:0]                    digit_bcd,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          bad_digit
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  // True if any nibble of v is outside the BCD range 0..9.
  function automatic logic has_bad(input logic [VAL_W-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  // Anode pattern and BCD code for slot idx of display value v.
  // Returns {anode, bcd}. Invalid or blanked slots are fully dark.
  function automatic logic [NUM_DIGITS+3:0] slot_drive(input logic [VAL_W-1:0] v,
                                                       input logic [IDX_W-1:0] idx,
                                                       input logic             lz);
    logic [3:0]            nib;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] onehot;
    nib        = 4'd0;
    upper_zero = 1'b1;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        nib       = v[4*i +: 4];
        onehot[i] = 1'b1;
      end
      // Slot is a leading zero only if it and every higher nibble are zero.
      if (i >= int'(idx) && v[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (nib > 4'd9 || (lz && idx != '0 && upper_zero)) begin
      return {ANODE_OFF, 4'd0};
    end
    // XOR with the idle pattern turns on exactly the selected digit.
    return {ANODE_OFF ^ onehot, nib};
  endfunction

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  run_q, run_d;
  logic [VAL_W-1:0]      pend_q, pend_d;
  logic                  pvld_q, pvld_d;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  ft_q, ft_d;
  logic                  bad_q, bad_d;

  logic slot_tick;
  logic wrap;

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    run_d   = run_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    disp_d  = disp_q;
    bcd_d   = bcd_q;
    anode_d = anode_q;
    ft_d    = 1'b0;

    slot_tick = (presc_q == PS_LAST);
    // run_q is low on the first enabled edge, which restarts at slot 0
    // rather than counting as a boundary.
    wrap      = run_q && slot_tick && (idx_q == IDX_LAST);

    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
      run_d   = 1'b0;
      anode_d = ANODE_OFF;
      bcd_d   = 4'd0;
      // Nothing is on screen, so a load can go straight to the display.
      if (load) disp_d = value;
    end else begin
      run_d = 1'b1;
      if (!run_q) begin
        presc_d = '0;
        idx_d   = '0;
      end else if (slot_tick) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      ft_d = wrap;
      if (wrap && pvld_q) begin
        disp_d = pend_q;
        pvld_d = 1'b0;
      end
      // A load coinciding with the wrap stays pending for the next boundary.
      if (load) begin
        pend_d = value;
        pvld_d = 1'b1;
      end
      // Drive from the next-state index and value so digit 0 of a new frame
      // already shows the new value.
      {anode_d, bcd_d} = slot_drive(disp_d, idx_d, lz_blank);
    end

    bad_d = has_bad(disp_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      disp_q  <= '0;
      bcd_q   <= 4'd0;
      anode_q <= ANODE_OFF;
      ft_q    <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      disp_q  <= disp_d;
      bcd_q   <= bcd_d;
      anode_q <= anode_d;
      ft_q    <= ft_d;
      bad_q   <= bad_d;
    end
  end

  assign digit_bcd  = bcd_q;
  assign anode      = anode_q;
  assign digit_idx  = idx_q;
  assign frame_tick = ft_q;
  assign bad_digit  = bad_q;

endmodule
